mul_sched_ctrl: RTL and testbench

- Scheduler and controller for the shared repeated-addition multiplier datapath: A register, B down-counter, P accumulator, and the eqz flag (asserted when B==0).
- Arbitrates among NREQ requesters using round-robin.
- Captures the granted requester's operands, sequences the datapath control strobes, and returns the product tagged with the requester ID.
- Sits between client blocks and one multiplier datapath instance; it replaces the fixed single-user controller.

---
 rtl/mul_sched_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mul_sched_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sched_ctrl.sv
// Round-robin scheduler/controller for a shared repeated-addition multiplier.
// Optional macro MUL_SCHED_OPSWAP_EN: swap operands at grant so B is the smaller one.
module mul_sched_ctrl #(
  parameter int W    = 16,
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      res_data,
  output logic [W-1:0]      dp_data,
  output logic              ldA,
  output logic              ldB,
  output logic              ldP,
  output logic              clrP,
  output logic              decB,
  input  logic              eqz,
  input  logic [W-1:0]      dp_y
);

  typedef enum logic [2:0] {
    IDLE,
    LDA,
    LDB,
    ACC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    id_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      dp_q;
  logic [W-1:0]      res_data_q;
  logic [IDW-1:0]    res_id_q;

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic              found;
  int                off;
  logic [IDW:0]      sum;
  logic [IDW-1:0]    pick;
  logic [IDW-1:0]    ptr_nx;
  logic [NREQ-1:0]   onehot;
  logic [W-1:0]      a_raw, b_raw;
  logic [W-1:0]      a_sel, b_sel;
  logic              take;

  // round-robin search: rotate req so rr_ptr sits at bit 0, take first set bit
  always_comb begin
    dbl   = {req, req};
    rot   = NREQ'(dbl >> rr_ptr);
    found = 1'b0;
    off   = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    sum = {1'b0, rr_ptr} + (IDW+1)'(off);
    if (sum >= (IDW+1)'(NREQ))
      sum = sum - (IDW+1)'(NREQ);
    pick   = sum[IDW-1:0];
    onehot = NREQ'(1) << pick;
    ptr_nx = (pick == IDW'(NREQ-1)) ? '0 : pick + 1'b1;
  end

  // operand mux for the winning requester, with optional swap
  always_comb begin
    a_raw = '0;
    b_raw = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == IDW'(k)) begin
        a_raw = a_in[k*W +: W];
        b_raw = b_in[k*W +: W];
      end
    end
`ifdef MUL_SCHED_OPSWAP_EN
    if (b_raw > a_raw) begin
      a_sel = b_raw;
      b_sel = a_raw;
    end else begin
      a_sel = a_raw;
      b_sel = b_raw;
    end
`else
    a_sel = a_raw;
    b_sel = b_raw;
`endif
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and per-state strobes
  always_comb begin
    state_nx  = state;
    gnt       = '0;
    busy      = 1'b1;
    res_valid = 1'b0;
    ldA       = 1'b0;
    ldB       = 1'b0;
    ldP       = 1'b0;
    clrP      = 1'b0;
    decB      = 1'b0;
    take      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (found && rst_n) begin
          gnt      = onehot;
          take     = 1'b1;
          state_nx = LDA;
        end
      end
      LDA: begin
        ldA      = 1'b1;
        state_nx = LDB;
      end
      LDB: begin
        ldB      = 1'b1;
        clrP     = 1'b1;
        state_nx = ACC;
      end
      ACC: begin
        if (eqz) begin
          state_nx = DONE;
        end else begin
          ldP  = 1'b1;
          decB = 1'b1;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand capture, dp bus and result hold registers
  // dp_q doubles as the latched A: it is loaded with A at grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      id_q       <= '0;
      b_q        <= '0;
      dp_q       <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      if (take) begin
        rr_ptr <= ptr_nx;
        id_q   <= pick;
        b_q    <= b_sel;
        dp_q   <= a_sel;
      end
      if (state == LDA)
        dp_q <= b_q;
      if (state == ACC && eqz) begin
        res_data_q <= dp_y;
        res_id_q   <= id_q;
      end
    end
  end

  assign dp_data  = dp_q;
  assign res_data = res_data_q;
  assign res_id   = res_id_q;

endmodule

// File: tb/tb_mul_sched_ctrl.sv
// Self-checking bench for mul_sched_ctrl with a behavioural datapath
// and an arithmetic reference model.
module tb_mul_sched_ctrl;

  localparam int W    = 16;
  localparam int NREQ = 2;
  localparam int IDW  = $clog2(NREQ);

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_data;
  logic [W-1:0]      dp_data;
  logic              ldA, ldB, ldP, clrP, decB;
  logic              eqz;
  logic [W-1:0]      dp_y;

  int pass_cnt = 0;
  int total    = 0;
  int model_ptr = 0;

  mul_sched_ctrl #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id),
    .res_data(res_data), .dp_data(dp_data), .ldA(ldA), .ldB(ldB),
    .ldP(ldP), .clrP(clrP), .decB(decB), .eqz(eqz), .dp_y(dp_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] dpA, dpB, dpP;
  assign eqz  = (dpB == '0);
  assign dp_y = dpP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dpA <= '0;
      dpB <= '0;
      dpP <= '0;
    end else begin
      if (ldA)  dpA <= dp_data;
      if (ldB)  dpB <= dp_data;
      if (clrP) dpP <= '0;
      else if (ldP) dpP <= dpP + dpA;
      if (decB) dpB <= dpB - 1'b1;
    end
  end

  function automatic logic [W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[W-1:0];
  endfunction

  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_SCHED_OPSWAP_EN
    return 4 + ((a < b) ? int'(a) : int'(b));
`else
    return 4 + int'(b);
`endif
  endfunction

  function automatic int ref_pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic run_txn(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int lda_at, output int ldb_at,
                         output int ldp_n, output logic [W-1:0] rd, output int rid,
                         output int gnt_bad);
    bit got;
    lat = -1; lda_at = -1; ldb_at = -1; ldp_n = 0; rd = '0; rid = -1; gnt_bad = 0;
    req = '0;
    req[id] = 1'b1;
    a_in[id*W +: W] = a;
    b_in[id*W +: W] = b;
    got = 0;
    for (int t = 0; t < 40; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      if (gnt != '0) begin
        got = 1;
        if (gnt !== NREQ'(1) << id) gnt_bad++;
        break;
      end
    end
    if (!got) begin
      gnt_bad++;
      req = '0;
      return;
    end
    model_ptr = (id + 1) % NREQ;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      if (c == 1) req = '0;
      #1;
      if (ldA) lda_at = c;
      if (ldB && clrP) ldb_at = c;
      if (ldP && decB) ldp_n++;
      if (gnt != '0) gnt_bad++;
      if (res_valid) begin
        lat = c;
        rd  = res_data;
        rid = int'(res_id);
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = '0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (gnt !== '0) $display("FAIL reset_gnt: got %0h expected 0", gnt); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else pass_cnt++;
    total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %0b expected 0", res_valid); else pass_cnt++;
    total++; if ({ldA, ldB, ldP, clrP, decB} !== 5'b0)
      $display("FAIL reset_strobes: got %05b expected 00000", {ldA, ldB, ldP, clrP, decB});
    else pass_cnt++;
    total++; if (res_data !== '0) $display("FAIL reset_res_data: got %0d expected 0", res_data); else pass_cnt++;
    total++; if (res_id !== '0) $display("FAIL reset_res_id: got %0d expected 0", res_id); else pass_cnt++;
    total++; if (dp_data !== '0) $display("FAIL reset_dp_data: got %0d expected 0", dp_data); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_basic;
    int lat, lda_at, ldb_at, ldp_n, rid, gb;
    logic [W-1:0] rd;
    run_txn(0, 16'd17, 16'd5, lat, lda_at, ldb_at, ldp_n, rd, rid, gb);
    total++; if (gb !== 0) $display("FAIL basic_gnt: bad grants %0d expected 0", gb); else pass_cnt++;
    total++; if (lda_at !== 1) $display("FAIL basic_ldA: at %0d expected 1", lda_at); else pass_cnt++;
    total++; if (ldb_at !== 2) $display("FAIL basic_ldB: at %0d expected 2", ldb_at); else pass_cnt++;
    total++; if (ldp_n !== 5) $display("FAIL basic_ldP: count %0d expected 5", ldp_n); else pass_cnt++;
    total++; if (lat !== 9) $display("FAIL basic_lat: got %0d expected 9", lat); else pass_cnt++;
    total++; if (rd !== 16'd85) $display("FAIL basic_data: got %0d expected 85", rd); else pass_cnt++;
    total++; if (rid !== 0) $display("FAIL basic_id: got %0d expected 0", rid); else pass_cnt++;
    @(negedge clk);
    #1;
    total++; if (res_data !== 16'd85 || res_valid !== 1'b0)
      $display("FAIL basic_hold: got data %0d valid %0b expected 85 0", res_data, res_valid);
    else pass_cnt++;
  endtask

  task automatic test_zero_b;
    int lat, lda_at, ldb_at, ldp_n, rid, gb;
    logic [W-1:0] rd;
    run_txn(1, 16'd9, 16'd0, lat, lda_at, ldb_at, ldp_n, rd, rid, gb);
    total++; if (gb !== 0) $display("FAIL zero_gnt: bad grants %0d expected 0", gb); else pass_cnt++;
    total++; if (ldp_n !== 0) $display("FAIL zero_ldP: count %0d expected 0", ldp_n); else pass_cnt++;
    total++; if (lat !== 4) $display("FAIL zero_lat: got %0d expected 4", lat); else pass_cnt++;
    total++; if (rd !== 16'd0) $display("FAIL zero_data: got %0d expected 0", rd); else pass_cnt++;
    total++; if (rid !== 1) $display("FAIL zero_id: got %0d expected 1", rid); else pass_cnt++;
  endtask

  task automatic test_overflow;
    int lat, lda_at, ldb_at, ldp_n, rid, gb;
    logic [W-1:0] rd;
    run_txn(0, 16'd300, 16'd300, lat, lda_at, ldb_at, ldp_n, rd, rid, gb);
    total++; if (rd !== 16'd24464) $display("FAIL ovf_data: got %0d expected 24464", rd); else pass_cnt++;
    total++; if (lat !== 304) $display("FAIL ovf_lat: got %0d expected 304", lat); else pass_cnt++;
  endtask

  task automatic test_random;
    int lat, lda_at, ldb_at, ldp_n, rid, gb, id, el;
    logic [W-1:0] rd, a, b, ep;
    for (int n = 0; n < 10; n++) begin
      id = int'($urandom_range(NREQ - 1, 0));
      a  = W'($urandom);
      b  = (n % 3 == 0) ? W'($urandom_range(25, 0)) : W'($urandom_range(12, 0));
      if (n == 4) a = W'($urandom_range(8, 0));
      ep = ref_prod(a, b);
      el = ref_lat(a, b);
      run_txn(id, a, b, lat, lda_at, ldb_at, ldp_n, rd, rid, gb);
      total++; if (rd !== ep || rid !== id)
        $display("FAIL rand_result: got data %0d id %0d expected %0d %0d", rd, rid, ep, id);
      else pass_cnt++;
      total++; if (lat !== el || ldp_n !== el - 4)
        $display("FAIL rand_timing: got lat %0d ldP %0d expected %0d %0d", lat, ldp_n, el, el - 4);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] av [NREQ];
    logic [W-1:0] bv [NREQ];
    int q[$];
    int exp, ngnt, head;
    for (int i = 0; i < NREQ; i++) begin
      av[i] = W'($urandom_range(1000, 1));
      bv[i] = W'($urandom_range(6, 0));
    end
    @(negedge clk);
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < 2; i++) begin
      a_in[i*W +: W] = av[i];
      b_in[i*W +: W] = bv[i];
    end
    req = '0;
    req[0] = 1'b1;
    req[1] = 1'b1;
    ngnt = 0;
    for (int c = 0; c < 80 || q.size() != 0; c++) begin
      if (c == 80) req = '0;
      if (c > 300) begin
        total++;
        $display("FAIL b2b_timeout: outstanding %0d expected 0", q.size());
        break;
      end
      #1;
      if (gnt != '0) begin
        exp = ref_pick(req);
        total++; if (busy !== 1'b0 || gnt !== NREQ'(1) << exp)
          $display("FAIL b2b_grant: got gnt %0h busy %0b expected %0h 0", gnt, busy, NREQ'(1) << exp);
        else pass_cnt++;
        q.push_back(exp);
        model_ptr = (exp + 1) % NREQ;
        ngnt++;
      end
      if (res_valid) begin
        head = (q.size() != 0) ? q.pop_front() : -1;
        total++;
        if (head < 0 || int'(res_id) !== head || res_data !== ref_prod(av[head < 0 ? 0 : head], bv[head < 0 ? 0 : head]))
          $display("FAIL b2b_result: got id %0d data %0d expected id %0d", res_id, res_data, head);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    total++; if (ngnt < 4) $display("FAIL b2b_count: got %0d grants expected at least 4", ngnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat, lda_at, ldb_at, ldp_n, rid, gb, rv;
    logic [W-1:0] rd;
    bit got;
    @(negedge clk);
    req = '0;
    req[0] = 1'b1;
    a_in[0 +: W] = 16'd20;
    b_in[0 +: W] = 16'd50;
    got = 0;
    for (int t = 0; t < 40; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      if (gnt[0]) begin got = 1; break; end
    end
    total++; if (!got) $display("FAIL mid_gnt: got none expected gnt[0]"); else pass_cnt++;
    @(negedge clk);
    req = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    req[1] = 1'b1;
    #1;
    total++; if ({gnt, busy, res_valid, ldA, ldB, ldP, clrP, decB} !== '0)
      $display("FAIL mid_outputs: got gnt %0h busy %0b rv %0b strobes %05b expected all 0",
               gnt, busy, res_valid, {ldA, ldB, ldP, clrP, decB});
    else pass_cnt++;
    total++; if (res_data !== '0 || res_id !== '0 || dp_data !== '0)
      $display("FAIL mid_regs: got data %0d id %0d dp %0d expected 0 0 0", res_data, res_id, dp_data);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    model_ptr = 0;
    rv = 0;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (res_valid) rv++;
      @(negedge clk);
    end
    total++; if (rv !== 0) $display("FAIL mid_no_result: got %0d strobes expected 0", rv); else pass_cnt++;
    run_txn(0, 16'd3, 16'd4, lat, lda_at, ldb_at, ldp_n, rd, rid, gb);
    total++; if (rd !== 16'd12 || rid !== 0)
      $display("FAIL mid_after: got data %0d id %0d expected 12 0", rd, rid);
    else pass_cnt++;
  endtask

  task automatic test_opswap;
    int lat, lda_at, ldb_at, ldp_n, rid, gb, el;
    logic [W-1:0] rd;
`ifdef MUL_SCHED_OPSWAP_EN
    el = 6;
`else
    el = 104;
`endif
    run_txn(1, 16'd2, 16'd100, lat, lda_at, ldb_at, ldp_n, rd, rid, gb);
    total++; if (lat !== el) $display("FAIL swap_lat: got %0d expected %0d", lat, el); else pass_cnt++;
    total++; if (ldp_n !== el - 4) $display("FAIL swap_ldP: got %0d expected %0d", ldp_n, el - 4); else pass_cnt++;
    total++; if (rd !== 16'd200 || rid !== 1)
      $display("FAIL swap_data: got %0d id %0d expected 200 1", rd, rid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_b;
    test_overflow;
    test_random;
    test_back_to_back;
    test_reset_mid;
    test_opswap;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
